// File: rtl/voice_allocator.sv
// voice_allocator
//   Accepts note requests from the song reader and assigns each one to a free
//   voice of the note player, lowest index first. Tracks the remaining
//   duration of every voice in beats and emits per-voice load strobes and
//   done pulses. With STEAL_EN set, a request arriving while all voices are
//   busy replaces the voice with the least time left (lowest index on ties).
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   play_enable   1 = count beats and accept requests, 0 = freeze
//   beat          one-cycle beat tick
//   req_valid     note request present
//   req_note      note code, sampled on accept
//   req_duration  length in beats, sampled on accept; 0 = rest
//   req_ready     request accepted this cycle when high together with req_valid
//   voice_load    one-cycle load strobe per voice
//   voice_note    held note per voice, voice i at [i*NOTE_W +: NOTE_W]
//   voice_active  voice i is sounding
//   voice_done    one-cycle pulse when voice i's duration runs out
//   steal_event   one-cycle pulse when an accepted note replaced a busy voice
//   all_idle      no voice active
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int STEAL_EN   = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play_enable,
    input  logic                         beat,
    input  logic                         req_valid,
    input  logic [NOTE_W-1:0]            req_note,
    input  logic [DUR_W-1:0]             req_duration,
    output logic                         req_ready,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES-1:0]        voice_done,
    output logic                         steal_event,
    output logic                         all_idle
);

    localparam int   IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic CAN_STEAL = (STEAL_EN != 0);

    logic [DUR_W-1:0] count [NUM_VOICES];
    logic [IDX_W-1:0] tgt;
    logic             any_free;
    logic             accept;
    logic             load_now;

    // A voice whose last beat lands this cycle is still active here, so it is
    // never chosen as free until the cycle after it expires.
    assign any_free  = |(~voice_active);
    assign req_ready = ~reset & play_enable & (any_free | CAN_STEAL);
    assign accept    = req_valid & req_ready;
    // Rests complete the handshake but load nothing.
    assign load_now  = accept & (req_duration != '0);
    assign all_idle  = ~|voice_active;

    // Target: lowest free voice, otherwise the busy voice with the smallest
    // count (strict < keeps the lowest index on ties).
    always_comb begin : target_select
        logic             found;
        logic [DUR_W-1:0] best;
        // NOTE: every variable gets a default before any conditional update,
        // otherwise the untaken paths would infer latches.
        found = 1'b0;
        best  = count[0];
        tgt   = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found && !voice_active[i]) begin
                found = 1'b1;
                tgt   = IDX_W'(i);
            end
        end
        if (!found) begin
            for (int i = 1; i < NUM_VOICES; i++) begin
                if (count[i] < best) begin
                    best = count[i];
                    tgt  = IDX_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the per-voice count array is small and feeds the steal
            // comparison, so it is reset like ordinary flops rather than
            // being treated as an unreset memory.
            for (int i = 0; i < NUM_VOICES; i++) begin
                count[i] <= '0;
            end
            voice_active <= '0;
            voice_note   <= '0;
            voice_load   <= '0;
            voice_done   <= '0;
            steal_event  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the strobe
            // defaults below are cleanly overridden by later assignments and
            // every read sees the pre-edge state.
            voice_load  <= '0;
            voice_done  <= '0;
            steal_event <= 1'b0;
            if (load_now) begin
                voice_load[tgt] <= 1'b1;
                steal_event     <= voice_active[tgt];
            end
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_now && (tgt == IDX_W'(i))) begin
                    // A loaded voice takes the full duration and skips this
                    // beat; a stolen voice therefore never reports done.
                    count[i]                          <= req_duration;
                    voice_active[i]                   <= 1'b1;
                    voice_note[i*NOTE_W +: NOTE_W]    <= req_note;
                end else if (play_enable && beat && voice_active[i]) begin
                    if (count[i] == DUR_W'(1)) begin
                        count[i]        <= '0;
                        voice_active[i] <= 1'b0;
                        voice_done[i]   <= 1'b1;
                    end else begin
                        count[i] <= count[i] - DUR_W'(1);
                    end
                end
            end
        end
    end

endmodule
